// File: rtl/pipe_driver_pkg.sv
// Shared defaults and the shadow-state update rule for the pipe driver.
package pipe_driver_pkg;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 8;

  // Predicted pipe result for a command, given the previous shadow state.
  function automatic logic [1:0] shadow_next(input logic [1:0] s, input logic a,
                                             input logic [1:0] d);
    return d ^ (a ? 2'b01 : s);
  endfunction
endpackage

// File: rtl/pipe_driver_if.sv
// Command handshake and pipe-side signals; master drives commands/results, slave is the driver.
interface pipe_driver_if;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic       cmd_action;
  logic [1:0] cmd_data;
  logic       in_vld;
  logic       action;
  logic [1:0] data;
  logic [1:0] out;
  logic       out_vld;

  modport master (output cmd_vld, cmd_action, cmd_data, out, out_vld,
                  input  cmd_rdy, in_vld, action, data);
  modport slave  (input  cmd_vld, cmd_action, cmd_data, out, out_vld,
                  output cmd_rdy, in_vld, action, data);
endinterface

// File: rtl/pipe_driver_fifo.sv
// Synchronous FIFO of predicted 2-bit results; head is read combinationally.
module pipe_driver_fifo
  import pipe_driver_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [1:0]    i_wdata,
  input  logic          i_pop,
  output logic [1:0]    o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || i_pop);
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
      if (w_pop)  r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/pipe_driver.sv
// Issues commands into a pipe, predicts each result and checks what comes back.
module pipe_driver
  import pipe_driver_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  pipe_driver_if.slave  bus,
  output logic [2:0]    outstanding,
  output logic [7:0]    done_cnt,
  output logic          err_mismatch,
  output logic          err_unexp,
  output logic          err_timeout
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AGW = $clog2(TIMEOUT + 1);

  logic [1:0]     r_shadow;
  logic           r_in_vld, r_action;
  logic [1:0]     r_data;
  logic [7:0]     r_done;
  logic           r_err_mis, r_err_unexp, r_err_to;
  logic [AGW-1:0] r_age, w_age_nxt;
  logic           w_acc, w_pop, w_full, w_empty;
  logic [1:0]     w_s_nxt, w_head;
  logic [CW-1:0]  w_count;

  // Readiness is purely occupancy-based so upstream never sees a path from out_vld.
  assign bus.cmd_rdy = !rst && (w_count < CW'(DEPTH));
  assign w_acc       = bus.cmd_vld && bus.cmd_rdy;
  assign w_pop       = bus.out_vld && !w_empty && !rst;
  assign w_s_nxt     = shadow_next(r_shadow, bus.cmd_action, bus.cmd_data);

  pipe_driver_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_acc),
    .i_wdata (w_s_nxt),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_age_nxt = r_age;
    if (w_empty || w_pop)            w_age_nxt = '0;
    else if (r_age != AGW'(TIMEOUT)) w_age_nxt = r_age + AGW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow    <= '0;
      r_in_vld    <= 1'b0;
      r_action    <= 1'b0;
      r_data      <= '0;
      r_done      <= '0;
      r_err_mis   <= 1'b0;
      r_err_unexp <= 1'b0;
      r_err_to    <= 1'b0;
      r_age       <= '0;
    end else begin
      r_in_vld <= w_acc;
      if (w_acc) begin
        r_shadow <= w_s_nxt;
        r_action <= bus.cmd_action;
        r_data   <= bus.cmd_data;
      end
      if (w_pop) begin
        r_done <= r_done + 8'd1;
        if (w_head != bus.out) r_err_mis <= 1'b1;
      end
      if (bus.out_vld && w_empty) r_err_unexp <= 1'b1;
      r_age <= w_age_nxt;
      if (w_age_nxt == AGW'(TIMEOUT)) r_err_to <= 1'b1;
    end
  end

  assign bus.in_vld   = r_in_vld;
  assign bus.action   = r_action;
  assign bus.data     = r_data;
  assign outstanding  = 3'(w_count);
  assign done_cnt     = r_done;
  assign err_mismatch = r_err_mis;
  assign err_unexp    = r_err_unexp;
  assign err_timeout  = r_err_to;

  logic w_unused;
  assign w_unused = w_full;
endmodule
